// File: rtl/rle_pkg.sv
// Shared types and constants for the RLE line decoder: FSM state encoding,
// run/bound widths and the pixel-index-to-state helper.
package rle_pkg;

   localparam int          RUN_W       = 13;
   localparam int          SUM_W       = RUN_W + 1;
   localparam logic [10:0] IMAGE_W_DEF = 11'd639;
   // Bounds are clipped to IMAGE_W+1, which always fits in one bit more than IMAGE_W.
   localparam int          BND_W       = 12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LEAD  = 2'd1,
      WHITE = 2'd2,
      TRAIL = 2'd3
   } state_e;

   function automatic state_e state_for(input logic [BND_W-1:0] idx,
                                        input logic [BND_W-1:0] b1,
                                        input logic [BND_W-1:0] b2);
      state_e s;
      if (idx < b1) begin
         s = LEAD;
      end else if (idx < b2) begin
         s = WHITE;
      end else begin
         s = TRAIL;
      end
      return s;
   endfunction

endpackage

// File: rtl/rle_run_bounds.sv
// Combinational run-bound clipper: converts lead/white run lengths into the
// pixel indices where LEAD ends (b1) and WHITE ends (b2), saturated at line length.
module rle_run_bounds
   import rle_pkg::*;
#(
   parameter logic [10:0] IMAGE_W = IMAGE_W_DEF,
   parameter int          RUN_W_P = RUN_W
) (
   input  logic [RUN_W_P-1:0] lead,
   input  logic [RUN_W_P-1:0] white,
   output logic [BND_W-1:0]   b1,
   output logic [BND_W-1:0]   b2
);

   // One extra bit so lead+white cannot wrap before clipping.
   localparam int S_W = RUN_W_P + 1;

   logic [S_W-1:0] line_s;
   logic [S_W-1:0] lead_s;
   logic [S_W-1:0] sum_s;

   assign line_s = S_W'(IMAGE_W) + S_W'(1'b1);
   assign lead_s = S_W'(lead);
   assign sum_s  = lead_s + S_W'(white);

   assign b1 = (lead_s < line_s) ? BND_W'(lead_s) : BND_W'(line_s);
   assign b2 = (sum_s  < line_s) ? BND_W'(sum_s)  : BND_W'(line_s);

endmodule

// File: rtl/rle_line_decoder.sv
// Replays one binary mask line per run triplet (lead black, white, trail black)
// at one pixel per requested cycle. Define RLE_DEC_CHECK_EN to enable the line-length check.
module rle_line_decoder #(
   parameter logic [10:0] IMAGE_W = rle_pkg::IMAGE_W_DEF,
   parameter int          RUN_W   = rle_pkg::RUN_W
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             load,
   input  logic [RUN_W-1:0] run_lead,
   input  logic [RUN_W-1:0] run_white,
   input  logic [RUN_W-1:0] run_trail,
   input  logic             pix_req,
   output logic             pixel_out,
   output logic             pixel_valid,
   output logic             line_done,
   output logic             busy,
   output logic             overrun,
   output logic             len_err
);
   import rle_pkg::*;

   localparam logic [BND_W-1:0] LAST_IDX = BND_W'(IMAGE_W);

   state_e           state_q, state_d;
   logic [BND_W-1:0] idx_q, idx_d;
   logic [BND_W-1:0] b1_q, b1_d, b2_q, b2_d;
   logic [RUN_W-1:0] pend_lead_q, pend_lead_d;
   logic [RUN_W-1:0] pend_white_q, pend_white_d;
   logic [RUN_W-1:0] pend_trail_q, pend_trail_d;
   logic             pend_v_q, pend_v_d;
   logic             pix_q, pix_d;
   logic             valid_q, valid_d;
   logic             done_q, done_d;
   logic             busy_q, busy_d;
   logic             overrun_q, overrun_d;
   logic             promote_s;
   logic [BND_W-1:0] pb1_s, pb2_s;

   rle_run_bounds #(
      .IMAGE_W (IMAGE_W),
      .RUN_W_P (RUN_W)
   ) u_bounds (
      .lead  (pend_lead_q),
      .white (pend_white_q),
      .b1    (pb1_s),
      .b2    (pb2_s)
   );

   // Next-state, emission and pending-slot control
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      b1_d         = b1_q;
      b2_d         = b2_q;
      pend_lead_d  = pend_lead_q;
      pend_white_d = pend_white_q;
      pend_trail_d = pend_trail_q;
      pend_v_d     = pend_v_q;
      pix_d        = pix_q;
      valid_d      = 1'b0;
      done_d       = 1'b0;
      overrun_d    = overrun_q;
      promote_s    = 1'b0;

      case (state_q)
         IDLE: begin
            if (pend_v_q) begin
               promote_s = 1'b1;
            end else begin
               promote_s = 1'b0;
            end
         end
         LEAD, WHITE, TRAIL: begin
            if (pix_req) begin
               pix_d   = (state_q == WHITE);
               valid_d = 1'b1;
               if (idx_q == LAST_IDX) begin
                  done_d = 1'b1;
                  idx_d  = '0;
                  if (pend_v_q) begin
                     promote_s = 1'b1;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  idx_d   = idx_q + BND_W'(1'b1);
                  state_d = state_for(idx_q + BND_W'(1'b1), b1_q, b2_q);
               end
            end else begin
               valid_d = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Promotion picks the state for idx 0 directly, so empty runs cost no cycle.
      if (promote_s) begin
         b1_d     = pb1_s;
         b2_d     = pb2_s;
         idx_d    = '0;
         state_d  = state_for('0, pb1_s, pb2_s);
         pend_v_d = 1'b0;
      end else begin
         b1_d = b1_q;
      end

      if (load) begin
         pend_lead_d  = run_lead;
         pend_white_d = run_white;
         pend_trail_d = run_trail;
         pend_v_d     = 1'b1;
         if (pend_v_q && !promote_s) begin
            overrun_d = 1'b1;
         end else begin
            overrun_d = overrun_q;
         end
      end else begin
         pend_v_d = pend_v_d;
      end

      busy_d = (state_d != IDLE);
   end

   // State, index, triplet storage and registered outputs
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         b1_q         <= '0;
         b2_q         <= '0;
         pend_lead_q  <= '0;
         pend_white_q <= '0;
         pend_trail_q <= '0;
         pend_v_q     <= 1'b0;
         pix_q        <= 1'b0;
         valid_q      <= 1'b0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         b1_q         <= b1_d;
         b2_q         <= b2_d;
         pend_lead_q  <= pend_lead_d;
         pend_white_q <= pend_white_d;
         pend_trail_q <= pend_trail_d;
         pend_v_q     <= pend_v_d;
         pix_q        <= pix_d;
         valid_q      <= valid_d;
         done_q       <= done_d;
         busy_q       <= busy_d;
         overrun_q    <= overrun_d;
      end
   end

   assign pixel_out   = pix_q;
   assign pixel_valid = valid_q;
   assign line_done   = done_q;
   assign busy        = busy_q;
   assign overrun     = overrun_q;

`ifdef RLE_DEC_CHECK_EN
   localparam int CHK_W = RUN_W + 2;

   logic [CHK_W-1:0] sum_s;
   logic             len_err_q, len_err_d;

   assign sum_s = CHK_W'(pend_lead_q) + CHK_W'(pend_white_q) + CHK_W'(pend_trail_q);

   // Sticky length mismatch, evaluated on the triplet being promoted
   always_comb begin
      len_err_d = len_err_q;
      if (promote_s && (sum_s != (CHK_W'(IMAGE_W) + CHK_W'(1'b1)))) begin
         len_err_d = 1'b1;
      end else begin
         len_err_d = len_err_q;
      end
   end

   // Length-error flag register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         len_err_q <= 1'b0;
      end else begin
         len_err_q <= len_err_d;
      end
   end

   assign len_err = len_err_q;
`else
   // Trail run only feeds the length check.
   logic unused_trail_s;
   assign unused_trail_s = ^pend_trail_q;
   assign len_err        = 1'b0;
`endif

endmodule

// File: tb/tb_rle_line_decoder.sv
// Directed self-checking bench for rle_line_decoder with a 16-pixel line.
module tb_rle_line_decoder;
   localparam logic [10:0] IMAGE_W = 11'd15;
   localparam int          RUN_W   = 13;

   logic             CLK;
   logic             RST;
   logic             load;
   logic [RUN_W-1:0] run_lead, run_white, run_trail;
   logic             pix_req;
   logic             pixel_out, pixel_valid, line_done, busy, overrun, len_err;

   int   n_checks;
   int   n_fail;
   int   scnt;
   int   first_v;
   int   last_v;
   int   mism;
   logic got_pix[$];
   int   done_cyc[$];
   logic exp_len_err;

   rle_line_decoder #(
      .IMAGE_W (IMAGE_W),
      .RUN_W   (RUN_W)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .load        (load),
      .run_lead    (run_lead),
      .run_white   (run_white),
      .run_trail   (run_trail),
      .pix_req     (pix_req),
      .pixel_out   (pixel_out),
      .pixel_valid (pixel_valid),
      .line_done   (line_done),
      .busy        (busy),
      .overrun     (overrun),
      .len_err     (len_err)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_rec();
      got_pix.delete();
      done_cyc.delete();
      scnt    = 0;
      first_v = -1;
      last_v  = -1;
   endtask

   // Each sample is taken on the falling edge, after the preceding rising edge.
   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         if (pixel_valid === 1'b1) begin
            got_pix.push_back(pixel_out);
            if (first_v < 0) first_v = scnt;
            last_v = scnt;
         end
         if (line_done === 1'b1) done_cyc.push_back(scnt);
         scnt++;
      end
   endtask

   task automatic load_run(input int l, input int w, input int t);
      load      = 1'b1;
      run_lead  = RUN_W'(l);
      run_white = RUN_W'(w);
      run_trail = RUN_W'(t);
      run(1);
      load = 1'b0;
   endtask

   function automatic logic [31:0] packed_pix();
      logic [31:0] v;
      v = 32'h0;
      for (int i = 0; i < got_pix.size() && i < 32; i++) v[i] = got_pix[i];
      return v;
   endfunction

   function automatic int done_at(input int k);
      if (done_cyc.size() > k) return done_cyc[k];
      return -1;
   endfunction

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      RST       = 1'b1;
      load      = 1'b0;
      pix_req   = 1'b0;
      run_lead  = '0;
      run_white = '0;
      run_trail = '0;
`ifdef RLE_DEC_CHECK_EN
      exp_len_err = 1'b1;
`else
      exp_len_err = 1'b0;
`endif
      clear_rec();

      // Reset state
      run(2);
      check("rst_pixel_out", {31'd0, pixel_out}, 32'd0);
      check("rst_pixel_valid", {31'd0, pixel_valid}, 32'd0);
      check("rst_line_done", {31'd0, line_done}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_overrun", {31'd0, overrun}, 32'd0);
      check("rst_len_err", {31'd0, len_err}, 32'd0);
      RST = 1'b0;
      run(2);

      // (4,6,6): 4 black, 6 white, 6 black; first valid two cycles after load
      clear_rec();
      pix_req = 1'b1;
      load_run(4, 6, 6);
      check("t1_idle_after_load", {31'd0, pixel_valid}, 32'd0);
      run(19);
      check("t1_first_valid", first_v, 32'd2);
      check("t1_count", got_pix.size(), 32'd16);
      check("t1_pattern", packed_pix(), 32'h0000_03F0);
      check("t1_done_cnt", done_cyc.size(), 32'd1);
      check("t1_done_at", done_at(0), 32'd17);
      check("t1_busy_end", {31'd0, busy}, 32'd0);
      check("t1_len_err", {31'd0, len_err}, 32'd0);

      // Back-to-back lines: all white then all black with no bubble
      clear_rec();
      load_run(0, 16, 0);
      run(4);
      load_run(16, 0, 0);
      run(40);
      check("t2_first_valid", first_v, 32'd2);
      check("t2_last_valid", last_v, 32'd33);
      check("t2_count", got_pix.size(), 32'd32);
      check("t2_pattern", packed_pix(), 32'h0000_FFFF);
      check("t2_done_cnt", done_cyc.size(), 32'd2);
      check("t2_done_gap", done_at(1) - done_at(0), 32'd16);
      check("t2_overrun", {31'd0, overrun}, 32'd0);

      // Overlong runs saturate at the line end
      clear_rec();
      load_run(10, 20, 0);
      run(20);
      check("t3_count", got_pix.size(), 32'd16);
      check("t3_pattern", packed_pix(), 32'h0000_FC00);
      check("t3_len_err", {31'd0, len_err}, {31'd0, exp_len_err});

      // pix_req toggling: valid mirrors the request sampled at the previous edge
      clear_rec();
      pix_req = 1'b0;
      load_run(3, 3, 10);
      run(1);
      mism = 0;
      for (int i = 0; i < 32; i++) begin
         pix_req = ((i % 2) == 0);
         run(1);
         if (pixel_valid !== pix_req) mism++;
      end
      check("t4_valid_follows_req", mism, 32'd0);
      check("t4_count", got_pix.size(), 32'd16);
      check("t4_pattern", packed_pix(), 32'h0000_0038);
      check("t4_done_cnt", done_cyc.size(), 32'd1);
      pix_req = 1'b1;
      run(2);

      // Three loads during an active line: overrun, last triplet wins
      clear_rec();
      load_run(4, 6, 6);
      run(3);
      load_run(0, 16, 0);
      check("t5_no_overrun_first", {31'd0, overrun}, 32'd0);
      load_run(16, 0, 0);
      load_run(2, 4, 10);
      run(40);
      check("t5_overrun", {31'd0, overrun}, 32'd1);
      check("t5_count", got_pix.size(), 32'd32);
      check("t5_pattern", packed_pix(), 32'h003C_03F0);
      check("t5_done_cnt", done_cyc.size(), 32'd2);

      // Load coincident with promotion, then async reset mid-line
      RST = 1'b1;
      run(1);
      RST = 1'b0;
      clear_rec();
      load_run(0, 16, 0);
      load_run(15, 0, 1);
      check("t6_no_overrun_promote", {31'd0, overrun}, 32'd0);
      for (int i = 0; i < 20 && got_pix.size() < 8; i++) run(1);
      check("t6_reach_pix7", got_pix.size(), 32'd8);
      check("t6_pattern", packed_pix(), 32'h0000_00FF);
      RST = 1'b1;
      #1;
      check("t6_async_pixel_out", {31'd0, pixel_out}, 32'd0);
      check("t6_async_valid", {31'd0, pixel_valid}, 32'd0);
      check("t6_async_done", {31'd0, line_done}, 32'd0);
      check("t6_async_busy", {31'd0, busy}, 32'd0);
      check("t6_async_overrun", {31'd0, overrun}, 32'd0);
      check("t6_async_len_err", {31'd0, len_err}, 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      clear_rec();
      run(40);
      check("t6_no_pixels_after_rst", got_pix.size(), 32'd0);
      check("t6_busy_after_rst", {31'd0, busy}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
